// File: rtl/fib_step_ctrl.sv
// fib_step_ctrl: sequencing controller for a chain of Fibonacci adder tiles.
//
// Issues single-cycle clock-enable pulses (chain_step) to every tile, either on
// manual command (IDLE) or at a fixed rate from a prescaler (RUN). It also
// re-initialises the chain (CLEAR), enforces an optional step limit and halts
// on adder overflow (HALT). All outputs are registered.
//
// Parameters:
//   RUN_PERIOD  clk cycles between auto-steps in RUN (2 .. 2^26-1)
//   CLR_CYCLES  chain_reset length in CLEAR (1 .. 15)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   cmd_run      pulse: start free-running stepping
//   cmd_stop     pulse: leave RUN
//   cmd_step     pulse: one manual step (IDLE only)
//   cmd_clear    pulse: re-initialise the chain
//   ovf          level: carry out of the top tile
//   max_steps    step limit, 0 = unlimited
//   chain_reset  reset to every tile
//   chain_step   one-cycle step enable to every tile
//   step_cnt     steps issued since the last CLEAR
//   busy         high in RUN
//   halted       high in HALT
//   state        IDLE=0, CLEAR=1, RUN=2, HALT=3
//
// Build option:
//   FIB_STEP_CTRL_AUTOWRAP_EN  overflow in RUN clears the chain and resumes RUN
//                              instead of halting.

module fib_step_ctrl #(
  parameter int unsigned RUN_PERIOD = 25000000,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_run,
  input  logic       cmd_stop,
  input  logic       cmd_step,
  input  logic       cmd_clear,
  input  logic       ovf,
  input  logic [7:0] max_steps,
  output logic       chain_reset,
  output logic       chain_step,
  output logic [7:0] step_cnt,
  output logic       busy,
  output logic       halted,
  output logic [1:0] state
);

  localparam logic [25:0] PrescLast = 26'(RUN_PERIOD - 1);
  localparam logic [3:0]  ClrLast   = 4'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StHalt  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic [3:0]  clr_q, clr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        restart_q, restart_d;
  logic        step_d;
  logic        chain_reset_d, busy_d, halted_d;
  logic        limit_hit;

  assign limit_hit = (max_steps != 8'd0) && (cnt_q == max_steps);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StClear;
      presc_q     <= '0;
      clr_q       <= '0;
      cnt_q       <= '0;
      restart_q   <= 1'b0;
      chain_reset <= 1'b1;
      chain_step  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      restart_q   <= restart_d;
      chain_reset <= chain_reset_d;
      chain_step  <= step_d;
      busy        <= busy_d;
      halted      <= halted_d;
    end
  end

  // Next state. Command priority: clear > stop > run > step.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    clr_d     = clr_q;
    cnt_d     = cnt_q;
    restart_d = restart_q;
    step_d    = 1'b0;

    unique case (state_q)
      StClear: begin
        if (clr_q == ClrLast) begin
          clr_d = '0;
          if (restart_q) begin
            state_d   = StRun;
            restart_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          clr_d = clr_q + 4'd1;
        end
      end
      StIdle: begin
        if (cmd_clear) begin
          state_d = StClear;
        end else if (ovf || limit_hit) begin
          state_d = StHalt;
        end else if (cmd_stop) begin
          // Stop has no effect in IDLE but still masks run/step.
          state_d = StIdle;
        end else if (cmd_run) begin
          state_d = StRun;
          presc_d = '0;
        end else if (cmd_step) begin
          step_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (cmd_clear) begin
          state_d = StClear;
        end else if (ovf) begin
`ifdef FIB_STEP_CTRL_AUTOWRAP_EN
          state_d   = StClear;
          restart_d = 1'b1;
`else
          state_d = StHalt;
`endif
        end else if (limit_hit) begin
          state_d = StHalt;
        end else if (cmd_stop) begin
          state_d = StIdle;
        end else if (presc_q == PrescLast) begin
          presc_d = '0;
          step_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          presc_d = presc_q + 26'd1;
        end
      end
      StHalt: begin
        if (cmd_clear) begin
          state_d = StClear;
        end
      end
      default: state_d = StClear;
    endcase

    // Any entry into CLEAR restarts its timer and zeroes the counters.
    if (state_d == StClear) begin
      cnt_d   = '0;
      presc_d = '0;
      if (state_q != StClear) begin
        clr_d = '0;
      end
    end
  end

  // Output decode of the next state, captured into the output registers.
  always_comb begin
    chain_reset_d = (state_d == StClear);
    busy_d        = (state_d == StRun);
    halted_d      = (state_d == StHalt);
  end

  assign step_cnt = cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fib_step_ctrl.sv
module tb_fib_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_run, cmd_stop, cmd_step, cmd_clear, ovf;
  logic [7:0] max_steps;
  logic       chain_reset, chain_step, busy, halted;
  logic [7:0] step_cnt;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fib_step_ctrl #(
    .RUN_PERIOD(4),
    .CLR_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_run    (cmd_run),
    .cmd_stop   (cmd_stop),
    .cmd_step   (cmd_step),
    .cmd_clear  (cmd_clear),
    .ovf        (ovf),
    .max_steps  (max_steps),
    .chain_reset(chain_reset),
    .chain_step (chain_step),
    .step_cnt   (step_cnt),
    .busy       (busy),
    .halted     (halted),
    .state      (state)
  );

  // Command encoding {run, stop, step, clear, ovf}.
  localparam logic [4:0] CN = 5'b00000;
  localparam logic [4:0] CR = 5'b10000;
  localparam logic [4:0] CS = 5'b01000;
  localparam logic [4:0] CP = 5'b00100;
  localparam logic [4:0] CC = 5'b00010;

  // Expected flags {chain_reset, chain_step, busy, halted, state[1:0]}.
  typedef struct {
    logic [4:0] cmd;
    logic [7:0] exp_cnt;
    logic [5:0] exp_flags;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {chain_reset, chain_step, busy, halted, state};
  endfunction

  task automatic do_clear(input string tag);
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    tick();
    tick();
    chk({tag, " clear->idle state"}, 32'(state), 32'd0);
    chk({tag, " clear cnt"}, 32'(step_cnt), 32'd0);
  endtask

  int npulse;

  initial begin
    vecs[0]  = '{CN,      8'd0, 6'b10_00_01};
    vecs[1]  = '{CN,      8'd0, 6'b00_00_00};
    vecs[2]  = '{CP,      8'd1, 6'b01_00_00};
    vecs[3]  = '{CN,      8'd1, 6'b00_00_00};
    vecs[4]  = '{CN,      8'd1, 6'b00_00_00};
    vecs[5]  = '{CP,      8'd2, 6'b01_00_00};
    vecs[6]  = '{CN,      8'd2, 6'b00_00_00};
    vecs[7]  = '{CS | CP, 8'd2, 6'b00_00_00};
    vecs[8]  = '{CR | CP, 8'd2, 6'b00_10_10};
    vecs[9]  = '{CN,      8'd2, 6'b00_10_10};
    vecs[10] = '{CN,      8'd2, 6'b00_10_10};
    vecs[11] = '{CN,      8'd2, 6'b00_10_10};
    vecs[12] = '{CN,      8'd3, 6'b01_10_10};
    vecs[13] = '{CS | CR, 8'd3, 6'b00_00_00};
    vecs[14] = '{CN,      8'd3, 6'b00_00_00};
    vecs[15] = '{CR,      8'd3, 6'b00_10_10};
    vecs[16] = '{CC | CR, 8'd0, 6'b10_00_01};
    vecs[17] = '{CP,      8'd0, 6'b10_00_01};
    vecs[18] = '{CR,      8'd0, 6'b00_00_00};
    vecs[19] = '{CN,      8'd0, 6'b00_00_00};

    reset = 1'b1;
    {cmd_run, cmd_stop, cmd_step, cmd_clear, ovf} = CN;
    max_steps = 8'd0;
    tick();
    tick();
    chk("reset flags", 32'(flags()), 32'(6'b10_00_01));
    chk("reset cnt", 32'(step_cnt), 32'd0);
    reset = 1'b0;

    // Table: release from reset, manual steps, priorities, RUN cadence, CLEAR.
    for (int i = 0; i < 20; i++) begin
      {cmd_run, cmd_stop, cmd_step, cmd_clear, ovf} = vecs[i].cmd;
      tick();
      {cmd_run, cmd_stop, cmd_step, cmd_clear, ovf} = CN;
      chk($sformatf("vec%0d cnt", i), 32'(step_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
    end

    // Three manual steps five cycles apart.
    for (int i = 0; i < 15; i++) begin
      cmd_step = (i % 5 == 0);
      tick();
      cmd_step = 1'b0;
      chk($sformatf("manual step cyc%0d", i), 32'(chain_step), 32'(i % 5 == 0));
    end
    chk("manual step cnt", 32'(step_cnt), 32'd3);

    // Step limit in RUN.
    do_clear("limit");
    max_steps = 8'd5;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    npulse = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (chain_step) begin
        chk($sformatf("run pulse %0d cycle", npulse), 32'(i), 32'(4 * (npulse + 1)));
        npulse++;
      end
    end
    chk("limit pulse count", 32'(npulse), 32'd5);
    chk("limit flags", 32'(flags()), 32'(6'b00_01_11));
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    tick();
    chk("halt step ignored cnt", 32'(step_cnt), 32'd5);
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    chk("halt run ignored", 32'(state), 32'd3);

    // Step limit in IDLE: a step right at the limit is dropped.
    do_clear("idle limit");
    max_steps = 8'd2;
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    tick();
    cmd_step = 1'b1;
    tick();
    chk("idle limit cnt2", 32'(step_cnt), 32'd2);
    tick();
    cmd_step = 1'b0;
    chk("idle limit flags", 32'(flags()), 32'(6'b00_01_11));
    chk("idle limit cnt", 32'(step_cnt), 32'd2);
    max_steps = 8'd0;

    // Overflow in RUN coinciding with a due step.
    do_clear("ovf run");
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    tick();
    tick();
    tick();
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("ovf run step suppressed", 32'(chain_step), 32'd0);
    chk("ovf run cnt", 32'(step_cnt), 32'd0);
`ifdef FIB_STEP_CTRL_AUTOWRAP_EN
    chk("ovf wrap clear1", 32'(flags()), 32'(6'b10_00_01));
    tick();
    chk("ovf wrap clear2", 32'(flags()), 32'(6'b10_00_01));
    tick();
    chk("ovf wrap resumed", 32'(flags()), 32'(6'b00_10_10));
    chk("ovf wrap cnt", 32'(step_cnt), 32'd0);
    tick();
    tick();
    tick();
    tick();
    chk("ovf wrap first pulse", 32'(chain_step), 32'd1);
    chk("ovf wrap pulse cnt", 32'(step_cnt), 32'd1);
`else
    chk("ovf run halt", 32'(flags()), 32'(6'b00_01_11));
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("ovf in halt ignored", 32'(state), 32'd3);
`endif

    // Overflow in IDLE halts in either build.
    do_clear("ovf idle");
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("ovf idle halt", 32'(flags()), 32'(6'b00_01_11));
    chk("ovf idle cnt", 32'(step_cnt), 32'd0);

    // 256 manual steps with no limit wrap the counter.
    do_clear("wrap");
    for (int i = 0; i < 256; i++) begin
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      tick();
      if (i == 254) chk("wrap cnt 255", 32'(step_cnt), 32'd255);
    end
    chk("wrap cnt 0", 32'(step_cnt), 32'd0);
    chk("wrap state", 32'(state), 32'd0);

    // Reset in the middle of CLEAR restarts the full CLEAR sequence.
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    reset = 1'b1;
    tick();
    chk("reset midclear flags", 32'(flags()), 32'(6'b10_00_01));
    reset = 1'b0;
    tick();
    chk("reset midclear cyc1", 32'(flags()), 32'(6'b10_00_01));
    tick();
    chk("reset midclear idle", 32'(flags()), 32'(6'b00_00_00));

    // Reset in the middle of RUN.
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset midrun flags", 32'(flags()), 32'(6'b10_00_01));
    chk("reset midrun cnt", 32'(step_cnt), 32'd0);
    tick();
    tick();
    chk("reset midrun idle", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
